// File: rtl/bt_uart_msg_tx_if.sv
// Serial line plus debug byte bundle for the free-running UART message transmitter.
// The master drives both the line and the byte shown on the debug LEDs.
interface bt_uart_msg_tx_if;
  logic       c;
  logic [7:0] d;

  modport master (output c, output d);
  modport slave  (input  c, input  d);
endinterface

// File: rtl/bt_uart_msg_tx.sv
// Free-running 8N1 UART that repeats "HELLO\r\n" with an idle gap; c/d are registered.
// Define BT_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module bt_uart_msg_tx #(
  parameter int CLK_DIV  = 5208,
  parameter int GAP_BITS = 10
) (
  input  logic               clk,
  input  logic               rst,
  bt_uart_msg_tx_if.master   tx
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_START,
    ST_DATA,
`ifdef BT_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_GAP
  } state_e;

  function automatic logic [7:0] msg_rom(input logic [2:0] i);
    case (i)
      3'd0:    msg_rom = 8'h48;
      3'd1:    msg_rom = 8'h45;
      3'd2:    msg_rom = 8'h4C;
      3'd3:    msg_rom = 8'h4C;
      3'd4:    msg_rom = 8'h4F;
      3'd5:    msg_rom = 8'h0D;
      3'd6:    msg_rom = 8'h0A;
      default: msg_rom = 8'h00;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      idx_q, idx_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            c_q, c_d;
  logic [7:0]      d_q, d_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      c_q     <= 1'b1;
      d_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end

  // All state moves happen on the last cycle of a bit-time, so c can change only at bit boundaries.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    c_d     = c_q;
    d_d     = d_q;
    if (baud_q == BAUD_LAST) begin
      baud_d = '0;
      case (state_q)
        ST_INIT: begin
          state_d = ST_START;
          c_d     = 1'b0;
          d_d     = msg_rom(idx_q);
        end
        ST_START: begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          c_d     = d_q[0];
        end
        ST_DATA: begin
          if (bit_q == 3'd7) begin
`ifdef BT_PARITY_EN
            state_d = ST_PARITY;
            c_d     = ^d_q;
`else
            state_d = ST_STOP;
            c_d     = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            c_d   = d_q[bit_q + 3'd1];
          end
        end
`ifdef BT_PARITY_EN
        ST_PARITY: begin
          state_d = ST_STOP;
          c_d     = 1'b1;
        end
`endif
        ST_STOP: begin
          if (idx_q != 3'd6) begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_START;
            c_d     = 1'b0;
            d_d     = msg_rom(idx_q + 3'd1);
          end else begin
            idx_d = 3'd0;
            if (GAP_BITS == 0) begin
              state_d = ST_START;
              c_d     = 1'b0;
              d_d     = msg_rom(3'd0);
            end else begin
              state_d = ST_GAP;
              gap_d   = '0;
              c_d     = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = ST_START;
            c_d     = 1'b0;
            d_d     = msg_rom(idx_q);
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        default: begin
          state_d = ST_INIT;
          c_d     = 1'b1;
        end
      endcase
    end
  end

  assign tx.c = c_q;
  assign tx.d = d_q;

endmodule

// File: tb/tb_bt_uart_msg_tx.sv
// Directed bench for bt_uart_msg_tx with CLK_DIV=4, GAP_BITS=2; outputs sampled on the falling edge.
// Cycle 0 is the first cycle with rst low; the start bit of frame f begins at cycle 4 + f*FL*4.
module tb_bt_uart_msg_tx;

  localparam int DIV  = 4;
  localparam int GAP  = 2;
`ifdef BT_PARITY_EN
  localparam int FL   = 11;
`else
  localparam int FL   = 10;
`endif
  localparam int LOGN = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errs   = 0;

  logic       c_log [LOGN];
  logic [7:0] d_log [LOGN];
  logic [7:0] msg   [7];

  bt_uart_msg_tx_if bus ();

  bt_uart_msg_tx #(.CLK_DIV(DIV), .GAP_BITS(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .tx  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Release rst so the next falling edge samples cycle 0.
  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [7:0] first_byte;
    logic [7:0] rx;
    int s;
    int msg_end;
    int t;

    msg[0] = 8'h48; msg[1] = 8'h45; msg[2] = 8'h4C; msg[3] = 8'h4C;
    msg[4] = 8'h4F; msg[5] = 8'h0D; msg[6] = 8'h0A;

    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_val("rst_c", {31'd0, bus.c}, 32'd1);
      check_val("rst_d", {24'd0, bus.d}, 32'h00);
    end

    release_rst();
    for (int i = 0; i < LOGN; i++) begin
      @(negedge clk);
      c_log[i] = bus.c;
      d_log[i] = bus.d;
    end

    for (int i = 0; i < 4; i++) begin
      check_val("init_c", {31'd0, c_log[i]}, 32'd1);
      check_val("init_d", {24'd0, d_log[i]}, 32'h00);
    end
    for (int i = 4; i < 8; i++) begin
      check_val("start0_c", {31'd0, c_log[i]}, 32'd0);
      check_val("start0_d", {24'd0, d_log[i]}, 32'h48);
    end
    first_byte = 8'h48;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < DIV; j++)
        check_val("data0_c", {31'd0, c_log[8 + k*DIV + j]}, {31'd0, first_byte[k]});
    for (int j = 0; j < DIV; j++)
      check_val("stop0_c", {31'd0, c_log[4 + (FL-1)*DIV + j]}, 32'd1);

    for (int f = 0; f < 7; f++) begin
      s  = 4 + f*FL*DIV;
      rx = 8'h00;
      check_val("frm_start_c", {31'd0, c_log[s+2]}, 32'd0);
      check_val("frm_start_d", {24'd0, d_log[s]}, {24'd0, msg[f]});
      for (int k = 0; k < 8; k++) begin
        rx[k] = c_log[s + DIV*(k+1) + 2];
        check_val("frm_hold_d", {24'd0, d_log[s + DIV*(k+1) + 2]}, {24'd0, msg[f]});
      end
      check_val("frm_byte", {24'd0, rx}, {24'd0, msg[f]});
`ifdef BT_PARITY_EN
      check_val("frm_par", {31'd0, c_log[s + DIV*9 + 2]}, {31'd0, ^msg[f]});
`endif
      check_val("frm_stop_c", {31'd0, c_log[s + DIV*(FL-1) + 2]}, 32'd1);
      check_val("frm_stop_d", {24'd0, d_log[s + DIV*FL - 1]}, {24'd0, msg[f]});
    end

`ifdef BT_PARITY_EN
    check_val("par_48", {31'd0, c_log[4 + 9*DIV + 2]}, 32'd0);
    check_val("par_45", {31'd0, c_log[4 + FL*DIV + 9*DIV + 2]}, 32'd1);
`endif

    msg_end = 4 + 7*FL*DIV;
    for (int i = 0; i < GAP*DIV; i++) begin
      check_val("gap_c", {31'd0, c_log[msg_end + i]}, 32'd1);
      check_val("gap_d", {24'd0, d_log[msg_end + i]}, 32'h0A);
    end
    check_val("wrap_c", {31'd0, c_log[4 + (7*FL + GAP)*DIV]}, 32'd0);
    check_val("wrap_d", {24'd0, d_log[4 + (7*FL + GAP)*DIV]}, 32'h48);
`ifndef BT_PARITY_EN
    check_val("wrap_288_c", {31'd0, c_log[292]}, 32'd0);
    check_val("wrap_288_pre", {31'd0, c_log[291]}, 32'd1);
`endif

    // Mid-frame reset during data bit 3 of the first 0x4C.
    rst = 1'b1;
    release_rst();
    t = 4 + 2*FL*DIV + 4*DIV + 1;
    for (int i = 0; i <= t; i++) @(negedge clk);
    check_val("mid_pre_c", {31'd0, bus.c}, 32'd1);
    check_val("mid_pre_d", {24'd0, bus.d}, 32'h4C);
    rst = 1'b1;
    release_rst();
    @(negedge clk);
    check_val("mid_rst_c", {31'd0, bus.c}, 32'd1);
    check_val("mid_rst_d", {24'd0, bus.d}, 32'h00);
    repeat (3) @(negedge clk);
    check_val("mid_init_c", {31'd0, bus.c}, 32'd1);
    @(negedge clk);
    check_val("mid_start_c", {31'd0, bus.c}, 32'd0);
    check_val("mid_start_d", {24'd0, bus.d}, 32'h48);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
